lsu_mem_fsm: RTL and testbench

- Parametrised multicycle load/store unit; successor to the single-cycle combinational memory-control stage in the EXU.
- Accepts one decoded memory op per handshake, computes the effective address and issues one request on a valid/ready memory port.
- Waits for the response, aligns and sign/zero-extends load data, and returns a result or error to writeback.
- Supports XLEN 32 or 64, misalignment trapping and a response timeout.

---
 rtl/lsu_mem_fsm_pkg.sv | 68 ++++++
 rtl/lsu_mem_fsm_align.sv | 60 ++++++
 rtl/lsu_mem_fsm.sv | 139 +++++++++++++
 tb/tb_lsu_mem_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_fsm_pkg.sv
// Shared LSU definitions: op codes, error codes, FSM states and op size/legality helpers.
// Pure declarations; no latency or backpressure of its own.
package lsu_mem_fsm_pkg;

  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_LWU = 4'h6;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_SD  = 4'hB;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam int unsigned CNT_W = 16;

  function automatic int unsigned lsu_mask_w(input int unsigned xlen);
    return xlen / 8;
  endfunction

  // Access size in bytes; 0 for codes that are not LSU ops.
  function automatic logic [3:0] op_size(input logic [3:0] op);
    logic [3:0] s;
    case (op)
      OP_LB, OP_LBU, OP_SB:         s = 4'd1;
      OP_LH, OP_LHU, OP_SH:         s = 4'd2;
      OP_LW, OP_LWU, OP_SW:         s = 4'd4;
      OP_LD, OP_SD:                 s = 4'd8;
      default:                      s = 4'd0;
    endcase
    return s;
  endfunction

  function automatic logic op_legal(input logic [3:0] op, input logic is64);
    logic l;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: l = 1'b1;
      OP_LD, OP_LWU, OP_SD:                                     l = is64;
      default:                                                  l = 1'b0;
    endcase
    return l;
  endfunction

  function automatic logic op_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/lsu_mem_fsm_align.sv
// Byte-lane alignment: store mask/data placement and load shift with sign/zero extension.
// Purely combinational, zero latency, no backpressure.
module lsu_mem_fsm_align
  import lsu_mem_fsm_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  localparam int unsigned MASK_W = XLEN / 8,
  localparam int unsigned OFF_W  = $clog2(MASK_W)
) (
  input  logic [3:0]        i_st_op,
  input  logic [OFF_W-1:0]  i_st_off,
  input  logic [XLEN-1:0]   i_st_wdata,
  input  logic [3:0]        i_ld_op,
  input  logic [OFF_W-1:0]  i_ld_off,
  input  logic [XLEN-1:0]   i_ld_rdata,
  output logic [MASK_W-1:0] o_wmask,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata
);

  logic [3:0]      w_st_size;
  logic [3:0]      w_ld_size;
  logic [XLEN-1:0] w_st_keep;
  logic [XLEN-1:0] w_ld_keep;
  logic [XLEN-1:0] w_ld_sh;
  logic            w_ld_sign;

  assign w_st_size = op_size(i_st_op);
  assign w_ld_size = op_size(i_ld_op);

  always_comb begin
    w_st_keep = '0;
    w_ld_keep = '0;
    o_wmask   = '0;
    for (int b = 0; b < int'(MASK_W); b++) begin
      if (b < int'(w_st_size)) w_st_keep[8*b +: 8] = 8'hFF;
      if (b < int'(w_ld_size)) w_ld_keep[8*b +: 8] = 8'hFF;
      if (op_store(i_st_op) && (b >= int'(i_st_off)) &&
          (b < int'(i_st_off) + int'(w_st_size)))
        o_wmask[b] = 1'b1;
    end
  end

  assign o_wdata = op_store(i_st_op) ? ((i_st_wdata & w_st_keep) << {i_st_off, 3'b000}) : '0;

  assign w_ld_sh = i_ld_rdata >> {i_ld_off, 3'b000};

  // Doubleword loads keep every bit, so their sign bit never matters.
  always_comb begin
    case (w_ld_size)
      4'd1:    w_ld_sign = w_ld_sh[7];
      4'd2:    w_ld_sign = w_ld_sh[15];
      default: w_ld_sign = w_ld_sh[31];
    endcase
    w_ld_sign = w_ld_sign & op_signed(i_ld_op);
  end

  assign o_rdata = (w_ld_sh & w_ld_keep) | ({XLEN{w_ld_sign}} & ~w_ld_keep);

endmodule

// File: rtl/lsu_mem_fsm.sv
// Multicycle load/store unit: one op in flight; req at accept+1, result 1 cycle after response (errors at accept+1).
// Backpressure: in_ready only in IDLE; request held stable until mem_req_ready; response timeout after TIMEOUT cycles.
module lsu_mem_fsm
  import lsu_mem_fsm_pkg::*;
#(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned MASK_W  = lsu_mask_w(XLEN),
  localparam int unsigned OFF_W   = $clog2(MASK_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [XLEN-1:0]   in_base,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_rdata,
  output logic [1:0]        out_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        r_state;
  logic [3:0]        r_op;
  logic [OFF_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;

  logic [XLEN-1:0]   w_ea;
  logic [OFF_W-1:0]  w_off;
  logic              w_illegal;
  logic              w_misal;
  logic [MASK_W-1:0] w_st_wmask;
  logic [XLEN-1:0]   w_st_wdata;
  logic [XLEN-1:0]   w_ld_rdata;

  assign w_ea      = in_base + in_imm;
  assign w_off     = w_ea[OFF_W-1:0];
  assign w_illegal = !op_legal(in_op, XLEN == 64);
  assign w_misal   = (w_off & OFF_W'(op_size(in_op) - 4'd1)) != '0;

  lsu_mem_fsm_align #(.XLEN(XLEN)) u_align (
    .i_st_op    (in_op),
    .i_st_off   (w_off),
    .i_st_wdata (in_wdata),
    .i_ld_op    (r_op),
    .i_ld_off   (r_off),
    .i_ld_rdata (mem_rdata),
    .o_wmask    (w_st_wmask),
    .o_wdata    (w_st_wdata),
    .o_rdata    (w_ld_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_off         <= '0;
      r_cnt         <= '0;
      in_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wmask     <= '0;
      mem_wdata     <= '0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_err       <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            r_op     <= in_op;
            r_off    <= w_off;
            if (w_illegal) begin
              r_state   <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= ERR_ILLEGAL;
            end else if (w_misal) begin
              r_state   <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= ERR_MISALIGN;
            end else begin
              r_state       <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= {w_ea[XLEN-1:OFF_W], {OFF_W{1'b0}}};
              mem_we        <= op_store(in_op);
              mem_wmask     <= w_st_wmask;
              mem_wdata     <= w_st_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response arriving on the final count still completes cleanly.
          if (mem_rsp_valid) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            out_err   <= ERR_NONE;
            out_rdata <= mem_we ? '0 : w_ld_rdata;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            out_err   <= ERR_TIMEOUT;
            out_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_rdata <= '0;
          out_err   <= ERR_NONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_fsm.sv
// Bench for lsu_mem_fsm: XLEN=32 and XLEN=64 instances (TIMEOUT=4) against a byte-arithmetic reference model.
module tb_lsu_mem_fsm;

  localparam int TMO = 4;
  localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LD = 4'h3, LBU = 4'h4, LHU = 4'h5,
                         LWU = 4'h6, SB = 4'h8, SH = 4'h9, SW = 4'hA, SD = 4'hB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel64 = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'h0;
  logic [63:0] in_base = '0, in_imm = '0, in_wdata = '0, mem_rdata = '0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;

  logic        a_in_ready, a_req_valid, a_we, a_out_valid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wmask;
  logic [1:0]  a_err;
  logic        b_in_ready, b_req_valid, b_we, b_out_valid;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [7:0]  b_wmask;
  logic [1:0]  b_err;

  lsu_mem_fsm #(.XLEN(32), .TIMEOUT(TMO)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel64), .in_ready(a_in_ready), .in_op(in_op),
    .in_base(in_base[31:0]), .in_imm(in_imm[31:0]), .in_wdata(in_wdata[31:0]),
    .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(a_addr),
    .mem_we(a_we), .mem_wmask(a_wmask), .mem_wdata(a_wdata),
    .mem_rsp_valid(mem_rsp_valid & ~sel64), .mem_rdata(mem_rdata[31:0]),
    .out_valid(a_out_valid), .out_rdata(a_rdata), .out_err(a_err)
  );

  lsu_mem_fsm #(.XLEN(64), .TIMEOUT(TMO)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel64), .in_ready(b_in_ready), .in_op(in_op),
    .in_base(in_base), .in_imm(in_imm), .in_wdata(in_wdata),
    .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(b_addr),
    .mem_we(b_we), .mem_wmask(b_wmask), .mem_wdata(b_wdata),
    .mem_rsp_valid(mem_rsp_valid & sel64), .mem_rdata(mem_rdata),
    .out_valid(b_out_valid), .out_rdata(b_rdata), .out_err(b_err)
  );

  // Outputs of whichever instance is selected, widened to 64 bits.
  logic [63:0] o_rdy, o_rqv, o_we, o_ov, o_addr, o_wdata, o_rdata, o_wmask, o_err;
  assign o_rdy   = 64'(sel64 ? b_in_ready  : a_in_ready);
  assign o_rqv   = 64'(sel64 ? b_req_valid : a_req_valid);
  assign o_we    = 64'(sel64 ? b_we        : a_we);
  assign o_ov    = 64'(sel64 ? b_out_valid : a_out_valid);
  assign o_addr  = sel64 ? b_addr  : {32'h0, a_addr};
  assign o_wdata = sel64 ? b_wdata : {32'h0, a_wdata};
  assign o_rdata = sel64 ? b_rdata : {32'h0, a_rdata};
  assign o_wmask = 64'(sel64 ? b_wmask : {4'h0, a_wmask});
  assign o_err   = 64'(sel64 ? b_err : a_err);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] wd;
    logic [63:0] rd;
    logic [1:0]  err;
    logic        st;
  } exp_t;

  function automatic exp_t model(input bit is64, input logic [3:0] op, input logic [63:0] base,
                                 input logic [63:0] imm, input logic [63:0] wd, input logic [63:0] rd);
    exp_t e;
    int sz, mw, off;
    bit sgn;
    logic [63:0] ea, v, rdx;
    e = '0;
    mw = is64 ? 8 : 4;
    case (op)
      LB, LBU, SB: sz = 1;
      LH, LHU, SH: sz = 2;
      LW, LWU, SW: sz = 4;
      LD, SD:      sz = 8;
      default:     sz = 0;
    endcase
    if (!is64 && (op == LD || op == SD || op == LWU)) sz = 0;
    sgn  = (op == LB) || (op == LH) || (op == LW);
    e.st = (op == SB) || (op == SH) || (op == SW) || (op == SD);
    ea   = base + imm;
    rdx  = rd;
    if (!is64) begin
      ea  = ea & 64'hFFFF_FFFF;
      rdx = rdx & 64'hFFFF_FFFF;
    end
    off = int'(ea % 64'(mw));
    if (sz == 0) begin e.err = 2'd3; return e; end
    if ((off % sz) != 0) begin e.err = 2'd1; return e; end
    e.addr = ea - 64'(off);
    if (e.st) begin
      e.mask = 8'(((1 << sz) - 1) << off);
      v      = (sz == 8) ? wd : (wd % (64'd1 << (8 * sz)));
      e.wd   = v << (8 * off);
    end else begin
      v = rdx >> (8 * off);
      if (sz < 8) begin
        v = v % (64'd1 << (8 * sz));
        if (sgn && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
      end
      if (!is64) v = v & 64'hFFFF_FFFF;
      e.rd = v;
    end
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ":in_ready"},  o_rdy,   64'd1);
    chk({tag, ":req_valid"}, o_rqv,   64'd0);
    chk({tag, ":we"},        o_we,    64'd0);
    chk({tag, ":wmask"},     o_wmask, 64'd0);
    chk({tag, ":addr"},      o_addr,  64'd0);
    chk({tag, ":wdata"},     o_wdata, 64'd0);
    chk({tag, ":out_valid"}, o_ov,    64'd0);
    chk({tag, ":rdata"},     o_rdata, 64'd0);
    chk({tag, ":err"},       o_err,   64'd0);
  endtask

  // rsp_d: WAIT cycle (0-based) carrying the response; negative means none.
  task automatic run_op(input bit is64, input logic [3:0] op, input logic [63:0] base,
                        input logic [63:0] imm, input logic [63:0] wd, input logic [63:0] rd,
                        input int req_wait, input int rsp_d, input string tag);
    exp_t e;
    bit ok_rsp;
    int done_d;
    e = model(is64, op, base, imm, wd, rd);
    sel64 = is64; in_op = op; in_base = base; in_imm = imm; in_wdata = wd; in_valid = 1'b1;
    chk({tag, ":accept_rdy"}, o_rdy, 64'd1);
    step();
    in_valid = 1'b0;
    in_base  = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom};
    if (e.err != 2'd0) begin
      chk({tag, ":early_valid"}, o_ov,    64'd1);
      chk({tag, ":early_err"},   o_err,   64'(e.err));
      chk({tag, ":early_rdata"}, o_rdata, 64'd0);
      chk({tag, ":no_req"},      o_rqv,   64'd0);
      chk({tag, ":busy"},        o_rdy,   64'd0);
      step();
      chk({tag, ":pulse_end"}, o_ov,  64'd0);
      chk({tag, ":idle_rdy"},  o_rdy, 64'd1);
      return;
    end
    for (int i = 0; i <= req_wait; i++) begin
      chk({tag, ":req_valid"}, o_rqv,   64'd1);
      chk({tag, ":addr"},      o_addr,  e.addr);
      chk({tag, ":we"},        o_we,    64'(e.st));
      chk({tag, ":wmask"},     o_wmask, 64'(e.mask));
      if (e.st) chk({tag, ":wdata"}, o_wdata, e.wd);
      chk({tag, ":req_busy"},  o_rdy,   64'd0);
      mem_req_ready = (i == req_wait);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      step();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk({tag, ":req_drop"}, o_rqv, 64'd0);
    ok_rsp = (rsp_d >= 0) && (rsp_d < TMO);
    done_d = ok_rsp ? rsp_d + 1 : TMO;
    for (int d = 0; d < done_d; d++) begin
      chk({tag, ":wait_quiet"}, o_ov, 64'd0);
      mem_rsp_valid = (d == rsp_d);
      mem_rdata     = (d == rsp_d) ? rd : {$urandom, $urandom};
      step();
    end
    mem_rsp_valid = (rsp_d == done_d);
    mem_rdata     = {$urandom, $urandom};
    chk({tag, ":done_valid"}, o_ov,    64'd1);
    chk({tag, ":done_err"},   o_err,   ok_rsp ? 64'd0 : 64'd2);
    chk({tag, ":done_rdata"}, o_rdata, ok_rsp ? e.rd : 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    chk({tag, ":pulse_end"}, o_ov,  64'd0);
    chk({tag, ":idle_rdy"},  o_rdy, 64'd1);
    chk({tag, ":idle_req"},  o_rqv, 64'd0);
  endtask

  logic [3:0] ops [12];

  initial begin
    ops = '{LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, 4'hF};

    rst = 1'b1;
    step();
    step();
    sel64 = 1'b0;
    chk_reset("rst32");
    sel64 = 1'b1;
    chk_reset("rst64");
    rst = 1'b0;

    run_op(0, SW,  64'h8000_0000, 64'd4, 64'hDEAD_BEEF, 64'd0,         0, 0,  "sw");
    run_op(0, SB,  64'h8000_0000, 64'd3, 64'h0000_00A5, 64'd0,         0, 0,  "sb");
    run_op(0, LB,  64'h8000_0000, 64'd2, 64'd0,         64'h00F0_0000, 0, 0,  "lb");
    run_op(0, LBU, 64'h8000_0000, 64'd2, 64'd0,         64'h00F0_0000, 0, 0,  "lbu");
    run_op(0, LH,  64'h8000_0000, 64'd2, 64'd0,         64'h8001_0000, 0, 0,  "lh");
    run_op(0, LW,  64'h8000_0000, 64'd2, 64'd0,         64'd0,         0, 0,  "lw_mis");
    run_op(0, LD,  64'h8000_0000, 64'd0, 64'd0,         64'd0,         0, 0,  "ld32");
    run_op(0, LW,  64'h8000_0010, 64'd0, 64'd0,         64'h1234_5678, 3, -1, "lw_tmo");
    run_op(0, LW,  64'h8000_0010, 64'd0, 64'd0,         64'h1234_5678, 3, 3,  "lw_last");
    run_op(1, LD,  64'h0000_0001_0000_0000, 64'd8, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0, "ld64");
    run_op(0, SH,  64'hFFFF_FFFE, 64'd4, 64'hCAFE_1234, 64'd0,         1, 1,  "sh_wrap");

    // Reset while waiting for a response; the late response must be dropped.
    sel64 = 1'b0; in_op = LW; in_base = 64'h8000_0000; in_imm = 64'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("rstw:in_wait", o_rqv, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0000_5555_AAAA;
    chk_reset("rstw0");
    step();
    mem_rsp_valid = 1'b0;
    chk_reset("rstw1");

    for (int i = 0; i < 80; i++) begin
      bit          is64;
      int          k;
      logic [63:0] base, imm;
      is64 = i[0];
      k    = int'($urandom_range(0, 32)) - 16;
      imm  = 64'(k);
      base = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) base[2:0] = 3'b000;
      run_op(is64, ops[$urandom_range(0, 11)], base, imm, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 2)), int'($urandom_range(0, 5)) - 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
